// File: rtl/hart_load_store_unit.sv
// hart_load_store_unit: one load or store per start over a req/ack data bus.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses.
module hart_load_store_unit #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            is_load,
    input  logic            is_store,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] store_val,
    output logic            busy,
    output logic            done,
    output logic            fault,
    output logic [XLEN-1:0] load_val,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nx;
    logic [1:0]      r_off;
    logic [1:0]      r_size;
    logic            r_load;

    logic [1:0]      off;
    logic            bad;
    logic [3:0]      be_c;
    logic [XLEN-1:0] wdata_c;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] ld_c;

    assign cnt_nx = cnt + CW'(1);

    // Decode the request: aligned lane offset, legality, enables, write data.
    always_comb begin
        off     = addr[1:0];
        be_c    = 4'b1111;
        wdata_c = '0;
        unique case (funct3[1:0])
            2'b00:   off = addr[1:0];
            2'b01:   off = {addr[1], 1'b0};
            default: off = 2'b00;
        endcase
        bad = (is_load && is_store)
            || (is_load && (funct3 == 3'b011 || funct3[2:1] == 2'b11))
            || (is_store && funct3 >= 3'b011);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((is_load || is_store)
            && ((funct3[1:0] == 2'b01 && addr[0])
                || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00)))
            bad = 1'b1;
`endif
        if (is_store) begin
            unique case (funct3[1:0])
                2'b00: begin
                    be_c    = 4'b0001 << off;
                    wdata_c = {4{store_val[7:0]}};
                end
                2'b01: begin
                    be_c    = 4'b0011 << off;
                    wdata_c = {2{store_val[15:0]}};
                end
                default: begin
                    be_c    = 4'b1111;
                    wdata_c = store_val;
                end
            endcase
        end
    end

    // Right-justify and zero-fill the addressed lanes of the returned word.
    always_comb begin
        shifted = mem_rdata >> {r_off, 3'b000};
        unique case (r_size)
            2'b00:   ld_c = {{(XLEN-8){1'b0}}, shifted[7:0]};
            2'b01:   ld_c = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: ld_c = shifted;
        endcase
    end

    // Access sequencer: IDLE -> (REQ) -> DONE with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            r_off     <= 2'b00;
            r_size    <= 2'b00;
            r_load    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
            load_val  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'b0000;
            mem_wdata <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        fault    <= 1'b0;
                        load_val <= '0;
                        cnt      <= '0;
                        r_off    <= off;
                        r_size   <= funct3[1:0];
                        r_load   <= is_load;
                        if (bad) begin
                            state <= DONE;
                            done  <= 1'b1;
                            fault <= 1'b1;
                        end else if (!is_load && !is_store) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {addr[XLEN-1:2], 2'b00};
                            mem_be    <= be_c;
                            mem_wdata <= wdata_c;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        if (r_load)
                            load_val <= ld_c;
                        state     <= DONE;
                        done      <= 1'b1;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_be    <= 4'b0000;
                        mem_wdata <= '0;
                    end else begin
                        cnt <= cnt_nx;
                        if (TIMEOUT_CYCLES != 0 && cnt_nx == TO_MAX) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            fault     <= 1'b1;
                            load_val  <= '0;
                            mem_req   <= 1'b0;
                            mem_we    <= 1'b0;
                            mem_addr  <= '0;
                            mem_be    <= 4'b0000;
                            mem_wdata <= '0;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hart_load_store_unit.sv
// tb_hart_load_store_unit: vector table, hand sequences and random accesses
// checked against a byte-lane reference model of the load/store unit.
module tb_hart_load_store_unit;

    localparam int TO = 4;

    logic        clk;
    logic        reset;
    logic        start;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_val;
    logic        busy;
    logic        done;
    logic        fault;
    logic [31:0] load_val;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int tests;
    int fails;

    typedef struct {
        bit          ld;
        bit          st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sv;
        logic [31:0] rdata;
        int          wt;
        bit          poke;
        bit          bus;
        bit          we;
        logic [31:0] maddr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          reqc;
        int          lat;
        bit          flt;
        logic [31:0] lv;
        bit          chk_lv;
    } vec_t;

    vec_t tbl[14];

    hart_load_store_unit #(
        .XLEN(32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .is_load(is_load),
        .is_store(is_store),
        .funct3(funct3),
        .addr(addr),
        .store_val(store_val),
        .busy(busy),
        .done(done),
        .fault(fault),
        .load_val(load_val),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_be(mem_be),
        .mem_wdata(mem_wdata),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference: byte-lane arithmetic straight from the access rules.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int sz;
        int off;
        bit bad;
        logic [63:0] mask;
        r = v;
        sz = (v.f3[1:0] == 2'b00) ? 1 : (v.f3[1:0] == 2'b01) ? 2 : 4;
        bad = (v.ld && v.st)
            || (v.ld && !(v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}))
            || (v.st && v.f3 > 3'd2);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((v.ld || v.st) && (v.addr % sz) != 0)
            bad = 1'b1;
`endif
        off = int'(v.addr % 4);
        off = off - (off % sz);
        r.bus = 0; r.we = 0; r.maddr = 0; r.be = 0; r.wdata = 0;
        r.reqc = 0; r.lat = 1; r.flt = 0; r.lv = 0; r.chk_lv = 0;
        if (bad) begin
            r.flt = 1;
        end else if (v.ld || v.st) begin
            r.bus = 1;
            r.we = v.st;
            r.maddr = v.addr - (v.addr % 4);
            if (v.st) begin
                r.be = 4'(((1 << sz) - 1) << off);
                for (int i = 0; i < 4; i++)
                    r.wdata[8*i +: 8] = v.sv[8*(i % sz) +: 8];
            end else begin
                r.be = 4'b1111;
            end
            r.chk_lv = v.ld;
            if (v.wt >= TO) begin
                r.reqc = TO;
                r.flt = 1;
                r.lv = 0;
            end else begin
                r.reqc = v.wt + 1;
                mask = (64'd1 << (8 * sz)) - 64'd1;
                r.lv = 32'((64'(v.rdata) >> (8 * off)) & mask);
            end
            r.lat = r.reqc + 1;
        end
        return r;
    endfunction

    task automatic do_access(input vec_t v, input string tag);
        int lat;
        int reqc;
        bit seen;
        @(negedge clk);
        start = 1'b1;
        is_load = v.ld;
        is_store = v.st;
        funct3 = v.f3;
        addr = v.addr;
        store_val = v.sv;
        @(negedge clk);
        start = v.poke;
        is_load = 1'($urandom);
        is_store = 1'($urandom);
        funct3 = 3'($urandom);
        addr = $urandom;
        store_val = $urandom;
        lat = 1;
        reqc = 0;
        seen = 0;
        while (!seen && lat < 40) begin
            mem_ack = 1'b0;
            mem_rdata = $urandom;
            if (done) begin
                seen = 1;
                start = 1'b0;
                chk({tag, ".lat"}, lat, v.lat);
                chk({tag, ".reqc"}, reqc, v.reqc);
                chk({tag, ".fault"}, fault, v.flt);
                chk({tag, ".busy_done"}, busy, 1'b1);
                chk({tag, ".req_done"}, mem_req, 1'b0);
                if (v.chk_lv)
                    chk({tag, ".load_val"}, load_val, v.lv);
            end else begin
                chk({tag, ".busy"}, busy, 1'b1);
                if (mem_req) begin
                    reqc++;
                    chk({tag, ".we"}, mem_we, v.we);
                    chk({tag, ".maddr"}, mem_addr, v.maddr);
                    chk({tag, ".be"}, mem_be, v.be);
                    chk({tag, ".wdata"}, mem_wdata, v.wdata);
                    if (reqc == v.wt + 1) begin
                        mem_ack = 1'b1;
                        mem_rdata = v.rdata;
                    end
                end else begin
                    chk({tag, ".bus_zero"},
                        mem_we | (|mem_be) | (|mem_addr) | (|mem_wdata), 0);
                end
                if (v.poke)
                    {is_load, is_store, funct3} = 5'($urandom);
                @(negedge clk);
                lat++;
            end
        end
        mem_ack = 1'b0;
        start = 1'b0;
        if (!seen)
            chk({tag, ".done_seen"}, 0, 1);
        @(negedge clk);
        chk({tag, ".done_pulse"}, done, 1'b0);
        chk({tag, ".busy_after"}, busy, 1'b0);
        @(negedge clk);
        chk({tag, ".no_queue"}, {done, mem_req}, 2'b00);
    endtask

    initial begin
        vec_t v;
        int r;
        tests = 0;
        fails = 0;
        reset = 1'b1;
        start = 1'b0;
        is_load = 1'b0;
        is_store = 1'b0;
        funct3 = 3'b000;
        addr = '0;
        store_val = '0;
        mem_ack = 1'b0;
        mem_rdata = '0;

        tbl[0]  = '{1'b0, 1'b1, 3'b000, 32'h103, 32'h12345678, 32'h0, 0, 1'b0,
                    1'b1, 1'b1, 32'h100, 4'b1000, 32'h78787878, 1, 2, 1'b0, 32'h0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 3'b000, 32'h202, 32'h0, 32'hAABBCCDD, 3, 1'b0,
                    1'b1, 1'b0, 32'h200, 4'b1111, 32'h0, 4, 5, 1'b0, 32'hBB, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h12345678, 99, 1'b1,
                    1'b1, 1'b0, 32'h300, 4'b1111, 32'h0, 4, 5, 1'b1, 32'h0, 1'b1};
`ifdef LSU_MISALIGN_TRAP_EN
        tbl[3]  = '{1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 32'h11223344, 0, 1'b0,
                    1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 0, 1, 1'b1, 32'h0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 3'b010, 32'h6, 32'h01020304, 32'h0, 0, 1'b0,
                    1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 0, 1, 1'b1, 32'h0, 1'b0};
`else
        tbl[3]  = '{1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 32'h11223344, 0, 1'b0,
                    1'b1, 1'b0, 32'h100, 4'b1111, 32'h0, 1, 2, 1'b0, 32'h3344, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 3'b010, 32'h6, 32'h01020304, 32'h0, 0, 1'b0,
                    1'b1, 1'b1, 32'h4, 4'b1111, 32'h01020304, 1, 2, 1'b0, 32'h0, 1'b0};
`endif
        tbl[4]  = '{1'b1, 1'b1, 3'b010, 32'h0, 32'h5, 32'h6, 0, 1'b0,
                    1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 0, 1, 1'b1, 32'h0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 3'b011, 32'h40, 32'h0, 32'h0, 0, 1'b0,
                    1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 0, 1, 1'b1, 32'h0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 3'b001, 32'h0A, 32'hCAFEBABE, 32'h0, 1, 1'b1,
                    1'b1, 1'b1, 32'h8, 4'b1100, 32'hBABEBABE, 2, 3, 1'b0, 32'h0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 3'b010, 32'h0, 32'hDEADBEEF, 32'h0, 0, 1'b0,
                    1'b1, 1'b1, 32'h0, 4'b1111, 32'hDEADBEEF, 1, 2, 1'b0, 32'h0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 3'b101, 32'h402, 32'h0, 32'h8899AABB, 2, 1'b0,
                    1'b1, 1'b0, 32'h400, 4'b1111, 32'h0, 3, 4, 1'b0, 32'h8899, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 3'b010, 32'h10, 32'h0, 32'h0, 0, 1'b0,
                    1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 0, 1, 1'b0, 32'h0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 3'b011, 32'h20, 32'h0, 32'h0, 0, 1'b0,
                    1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 0, 1, 1'b1, 32'h0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 3'b100, 32'h7, 32'h0, 32'hF1E2D3C4, 0, 1'b0,
                    1'b1, 1'b0, 32'h4, 4'b1111, 32'h0, 1, 2, 1'b0, 32'hF1, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 3'b010, 32'h8, 32'h0, 32'h13579BDF, 3, 1'b0,
                    1'b1, 1'b0, 32'h8, 4'b1111, 32'h0, 4, 5, 1'b0, 32'h13579BDF, 1'b1};

        @(negedge clk);
        @(negedge clk);
        chk("reset.outs", {busy, done, fault, mem_req, mem_we, mem_be}, 0);
        chk("reset.load_val", load_val, 32'h0);
        chk("reset.buses", mem_addr | mem_wdata, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++)
            do_access(tbl[i], $sformatf("vec%0d", i));

        @(negedge clk);
        start = 1'b1;
        is_load = 1'b1;
        is_store = 1'b0;
        funct3 = 3'b010;
        addr = 32'h500;
        @(negedge clk);
        start = 1'b0;
        chk("rst.req1", mem_req, 1'b1);
        @(negedge clk);
        chk("rst.req2", mem_req, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk("rst.async", {mem_req, busy, done}, 3'b000);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst.no_done", {done, busy, mem_req}, 3'b000);
        end
        do_access(tbl[7], "rst.sw");

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            v.ld = (r == 0) || (r >= 2 && r <= 5);
            v.st = (r == 0) || (r >= 6);
            v.f3 = v.st && !v.ld ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            v.addr = $urandom;
            v.sv = $urandom;
            v.rdata = $urandom;
            v.wt = $urandom_range(0, 5);
            v.poke = 1'($urandom);
            v = model(v);
            do_access(v, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hart_load_store_unit.md
Name: hart_load_store_unit

Overview:
- Memory-access stage for the hart's data memory; sits between the decoded instruction and the execute stage's `load_val` input, and also carries the execute stage's `store_val`/`store_enable` out to the data bus.
- Runs one load or store per `start` over a req/ack data-memory handshake.
- Generates byte enables and lane-replicated write data.
- Returns load data right-justified and zero-filled, so the execute stage performs all sign/zero extension.

Parameters:
- XLEN, 32, data/address width (the isa_types value; only 32 is supported).
- TIMEOUT_CYCLES, 255, maximum number of cycles in REQ without `mem_ack` before aborting; 0 disables the timeout.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- start  input  1  launch an access; sampled only in IDLE.
- is_load  input  1  access is a load (OPCODE_LOAD).
- is_store  input  1  access is a store (OPCODE_STORE).
- funct3  input  3  width code: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010.
- addr  input  XLEN  effective byte address (rs1 + imm).
- store_val  input  XLEN  rs2 value for stores.
- busy  output  1  high from the cycle after an accepted start until the done cycle, inclusive.
- done  output  1  one-cycle completion pulse.
- fault  output  1  valid when `done` is high; held until the next accepted start.
- load_val  output  XLEN  right-justified load data; held until the next accepted start.
- mem_req  output  1  bus request.
- mem_we  output  1  1 = write.
- mem_addr  output  XLEN  word-aligned address: {addr[31:2], 2'b00}.
- mem_be  output  4  byte enables.
- mem_wdata  output  XLEN  write data.
- mem_ack  input  1  completion; valid only while `mem_req` is high.
- mem_rdata  input  XLEN  read data, valid with `mem_ack`.

Behaviour:
- Clock and reset: one clock domain, `clk`. `reset` is asynchronous and active-high.
- Reset values: every output is 0, FSM in IDLE, timeout counter 0.
- Reset mid-transaction: `mem_req` drops immediately, and no `done` is produced for the aborted access.
- FSM states: IDLE, REQ, DONE.
  - IDLE: on `start`, register `addr`, `funct3`, `is_load`, `is_store` and `store_val`, then check the access.
    - Invalid access goes straight to DONE with `fault`=1 and no bus cycle. Invalid means:
      - `is_load` and `is_store` both high;
      - load `funct3` in {011, 110, 111};
      - store `funct3` ≥ 011.
    - Neither `is_load` nor `is_store` high: go to DONE with `fault`=0 (no-op).
    - Otherwise go to REQ.
  - REQ: `mem_req`=1 and all `mem_*` outputs held stable until `mem_ack`.
    - On `mem_ack`, capture `load_val` (loads) and go to DONE.
    - Counter increments each REQ cycle. If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES without `mem_ack`, drop `mem_req` and go to DONE with `fault`=1; `load_val` is 0.
  - DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` while not in IDLE is ignored, with no queueing.
- Minimum latency: `start` at cycle 0 → `mem_req` at cycle 1 → `mem_ack` at cycle 1 → `done` at cycle 2.
- Byte lane o = addr[1:0].
- Stores (`mem_we`=1):
  - SB: `mem_be` = 4'b0001<<o, `mem_wdata` = {4{store_val[7:0]}}.
  - SH: `mem_be` = 4'b0011<<o, `mem_wdata` = {2{store_val[15:0]}}.
  - SW: `mem_be` = 4'b1111, `mem_wdata` = store_val.
- Loads (`mem_we`=0, `mem_be` = 4'b1111):
  - Byte: `load_val` = {24'b0, mem_rdata >> 8·o [7:0]}.
  - Half: `load_val` = {16'b0, mem_rdata >> 8·o [15:0]}.
  - Word: `load_val` = `mem_rdata`.
- `mem_*` outputs are 0 whenever `mem_req`=0.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - A halfword with addr[0]=1, or a word with addr[1:0]≠0, goes IDLE→DONE with `fault`=1 and no bus cycle.
- Undefined:
  - The offset is forced to natural alignment: half uses o = {addr[1],0}; word uses o = 0.
  - The access proceeds normally, and misalignment never causes `fault`.

Test Plan:
- SB, addr=0x103, store_val=0x12345678, ack 1 cycle after req → `mem_addr`=0x100, `mem_be`=1000, `mem_wdata`=0x78787878, `done` 2 cycles after start, `fault`=0.
- LB, addr=0x202, `mem_rdata`=0xAABBCCDD, ack after 3 wait cycles → `load_val`=0x000000BB, `done` 5 cycles after start.
- LW, addr=0x300, TIMEOUT_CYCLES=4, ack never asserted → `mem_req` high exactly 4 cycles, then `done`=1, `fault`=1, `load_val`=0.
- LH, addr=0x101:
  - With LSU_MISALIGN_TRAP_EN: `fault`=1, `mem_req` never asserted.
  - Without it: access at 0x100, `mem_rdata`=0x11223344 → `load_val`=0x00003344.
- `start` with `is_load` and `is_store` both high, or load `funct3`=011 → `done` next cycle, `fault`=1, no `mem_req`; a second `start` while busy is ignored.
- Reset asserted in REQ cycle 2 → `mem_req`, `busy`, `done` go 0 immediately; a following SW to 0x0 with store_val=0xDEADBEEF → `mem_be`=1111, `mem_wdata`=0xDEADBEEF.
